// File: rtl/mem_ctrl_if.sv
// Requester-side and memory-bus signals of the byte-serial memory controller.
// master = the environment (requesters, RAM/HCI), slave = mem_ctrl itself.
interface mem_ctrl_if;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_abort;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    output rdy_in, if_req, if_addr, if_abort, ls_req, ls_wr, ls_size,
           ls_addr, ls_wdata, mem_din, io_buffer_full,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  rdy_in, if_req, if_addr, if_abort, ls_req, ls_wr, ls_size,
           ls_addr, ls_wdata, mem_din, io_buffer_full,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction-fetch and load/store
// requests and serialises each 1/2/4-byte access into single-byte bus cycles,
// honouring rdy_in pauses and HCI output back-pressure on I/O stores.
module mem_ctrl #(
  parameter int IO_SEL_HI = 17
) (
  input  logic      clk_in,
  input  logic      rst_in,
  mem_ctrl_if.slave mc_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IO_WAIT = 3'd1,
    S_READ    = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;            // issue index: next byte to put on the bus
  logic [2:0]  j_q, j_d;            // capture index: next byte lane to fill
  logic        pend_q, pend_d;      // a read byte was issued last cycle with rdy_in = 1
  logic [31:0] base_q, base_d;
  logic [1:0]  last_q, last_d;      // index of the final byte (0, 1 or 3)
  logic [31:0] wdata_q, wdata_d;
  logic        is_ls_q, is_ls_d;
  logic [31:0] buf_q, buf_d;        // read assembly buffer, kept apart from the outputs
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic [2:0]  n_s;

  logic [31:0] mem_a_s;
  logic        mem_wr_s;
  logic [7:0]  mem_dout_s;
  logic        if_done_s;
  logic        ls_done_s;

  function automatic logic [1:0] size_to_last(input logic [1:0] size);
    case (size)
      2'd0:    size_to_last = 2'd0;
      2'd1:    size_to_last = 2'd1;
      default: size_to_last = 2'd3;
    endcase
  endfunction

  function automatic logic is_io_addr(input logic [31:0] addr);
    is_io_addr = (addr[IO_SEL_HI -: 2] == 2'b11);
  endfunction

  function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  data);
    logic [31:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      default: res[31:24] = data;
    endcase
    insert_lane = res;
  endfunction

  function automatic logic [7:0] select_lane(input logic [31:0] word,
                                             input logic [1:0]  lane);
    case (lane)
      2'd0:    select_lane = word[7:0];
      2'd1:    select_lane = word[15:8];
      2'd2:    select_lane = word[23:16];
      default: select_lane = word[31:24];
    endcase
  endfunction

  assign n_s = {1'b0, last_q} + 3'd1;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      k_q        <= 3'd0;
      j_q        <= 3'd0;
      pend_q     <= 1'b0;
      base_q     <= 32'd0;
      last_q     <= 2'd0;
      wdata_q    <= 32'd0;
      is_ls_q    <= 1'b0;
      buf_q      <= 32'd0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      j_q        <= j_d;
      pend_q     <= pend_d;
      base_q     <= base_d;
      last_q     <= last_d;
      wdata_q    <= wdata_d;
      is_ls_q    <= is_ls_d;
      buf_q      <= buf_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Next-state: arbitration, byte issue/capture bookkeeping, pause and abort handling.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    j_d        = j_q;
    pend_d     = pend_q;
    base_d     = base_q;
    last_d     = last_q;
    wdata_d    = wdata_q;
    is_ls_d    = is_ls_q;
    buf_d      = buf_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      S_IDLE: begin
        k_d    = 3'd0;
        j_d    = 3'd0;
        pend_d = 1'b0;
        if (mc_if.rdy_in && mc_if.ls_req) begin
          base_d  = mc_if.ls_addr;
          last_d  = size_to_last(mc_if.ls_size);
          wdata_d = mc_if.ls_wdata;
          is_ls_d = 1'b1;
          buf_d   = 32'd0;
          if (!mc_if.ls_wr) begin
            state_d = S_READ;
          end else if (is_io_addr(mc_if.ls_addr) && mc_if.io_buffer_full) begin
            state_d = S_IO_WAIT;
          end else begin
            state_d = S_WRITE;
          end
        end else if (mc_if.rdy_in && mc_if.if_req && !mc_if.if_abort) begin
          base_d  = mc_if.if_addr;
          last_d  = 2'd3;
          wdata_d = 32'd0;
          is_ls_d = 1'b0;
          buf_d   = 32'd0;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IO_WAIT: begin
        if (mc_if.rdy_in && !mc_if.io_buffer_full) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_IO_WAIT;
        end
      end
      S_READ: begin
        if (mc_if.if_abort && !is_ls_q) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
        end else begin
          // The byte issued last cycle (with rdy_in high) is on mem_din now.
          if (pend_q) begin
            buf_d = insert_lane(buf_q, j_q[1:0], mc_if.mem_din);
            j_d   = j_q + 3'd1;
          end else begin
            buf_d = buf_q;
          end
          if (!mc_if.rdy_in) begin
            // Whatever goes out during a pause is dropped; restart at first gap.
            k_d    = j_d;
            pend_d = 1'b0;
          end else if (j_d == n_s) begin
            state_d = S_DONE;
            pend_d  = 1'b0;
            if (is_ls_q) begin
              ls_rdata_d = buf_d;
            end else begin
              if_data_d = buf_d;
            end
          end else if (k_q < n_s) begin
            k_d    = k_q + 3'd1;
            pend_d = 1'b1;
          end else begin
            pend_d = 1'b0;
          end
        end
      end
      S_WRITE: begin
        if (mc_if.rdy_in) begin
          k_d = k_q + 3'd1;
          if (k_q == n_s - 3'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus and done outputs decoded from the current state; pauses mask mem_wr.
  always_comb begin
    mem_a_s    = 32'd0;
    mem_wr_s   = 1'b0;
    mem_dout_s = 8'd0;
    if_done_s  = 1'b0;
    ls_done_s  = 1'b0;
    case (state_q)
      S_READ: begin
        if (k_q < n_s) begin
          mem_a_s = base_q + {29'd0, k_q};
        end else begin
          mem_a_s = 32'd0;
        end
      end
      S_WRITE: begin
        mem_a_s    = base_q + {29'd0, k_q};
        mem_dout_s = select_lane(wdata_q, k_q[1:0]);
        mem_wr_s   = mc_if.rdy_in;
      end
      S_DONE: begin
        if (is_ls_q) begin
          ls_done_s = 1'b1;
        end else begin
          if_done_s = 1'b1;
        end
      end
      default: begin
        mem_a_s = 32'd0;
      end
    endcase
  end

  assign mc_if.mem_a    = mem_a_s;
  assign mc_if.mem_wr   = mem_wr_s;
  assign mc_if.mem_dout = mem_dout_s;
  assign mc_if.if_done  = if_done_s;
  assign mc_if.ls_done  = ls_done_s;
  assign mc_if.if_data  = if_data_q;
  assign mc_if.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide RAM model.
module tb_mem_ctrl;
  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  mem_ctrl_if mc();

  mem_ctrl #(.IO_SEL_HI(17)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .mc_if  (mc)
  );

  logic [7:0] ram [logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle logs of one run, index = cycle number C0..Cn.
  logic [31:0] a_log      [0:31];
  logic [7:0]  dout_log   [0:31];
  logic [31:0] ifdata_log [0:31];
  logic [31:0] lsrd_log   [0:31];
  logic [31:0] wr_log;
  logic [31:0] ifd_log;
  logic [31:0] lsd_log;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    else return 8'h00;
  endfunction

  // RAM read port: data for the address of one cycle appears the next cycle.
  always @(posedge clk_in) mc.mem_din <= ram_rd(mc.mem_a);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Run cycles C0..Cn; per-cycle controls are applied just after each rising edge.
  task automatic run(input int n, input int full_lo, input int full_hi,
                     input int pause_lo, input int pause_hi,
                     input int abort_at, input int rst_at);
    logic if_seen;
    logic ls_seen;
    if_seen = 1'b0;
    ls_seen = 1'b0;
    wr_log  = 32'd0;
    ifd_log = 32'd0;
    lsd_log = 32'd0;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(posedge clk_in);
        #1;
      end
      mc.rdy_in         = !(c >= pause_lo && c <= pause_hi);
      mc.io_buffer_full = (c >= full_lo && c <= full_hi);
      mc.if_abort       = (c == abort_at);
      rst_in            = (c != rst_at);
      if (c == abort_at) mc.if_req = 1'b0;
      if (c == rst_at) begin
        mc.ls_req = 1'b0;
        mc.if_req = 1'b0;
      end
      if (if_seen) mc.if_req = 1'b0;
      if (ls_seen) mc.ls_req = 1'b0;
      @(negedge clk_in);
      a_log[c]      = mc.mem_a;
      dout_log[c]   = mc.mem_dout;
      ifdata_log[c] = mc.if_data;
      lsrd_log[c]   = mc.ls_rdata;
      wr_log[c]     = mc.mem_wr;
      ifd_log[c]    = mc.if_done;
      lsd_log[c]    = mc.ls_done;
      if (mc.if_done) if_seen = 1'b1;
      if (mc.ls_done) ls_seen = 1'b1;
    end
  endtask

  task automatic new_cycle();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b0;
    mc.rdy_in = 1'b1;
    mc.if_req = 1'b0;
    mc.if_addr = 32'd0;
    mc.if_abort = 1'b0;
    mc.ls_req = 1'b0;
    mc.ls_wr = 1'b0;
    mc.ls_size = 2'd0;
    mc.ls_addr = 32'd0;
    mc.ls_wdata = 32'd0;
    mc.io_buffer_full = 1'b0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h1004] = 8'h11; ram[32'h1005] = 8'h22; ram[32'h1006] = 8'h33; ram[32'h1007] = 8'h44;
    ram[32'h2000] = 8'h7F;
    ram[32'h3000] = 8'hDE; ram[32'h3001] = 8'hAD; ram[32'h3002] = 8'hBE; ram[32'h3003] = 8'hEF;

    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    check_eq("rst_mem_a", mc.mem_a, 32'd0);
    check_eq("rst_mem_wr", {31'd0, mc.mem_wr}, 32'd0);
    check_eq("rst_mem_dout", {24'd0, mc.mem_dout}, 32'd0);
    check_eq("rst_if_done", {31'd0, mc.if_done}, 32'd0);
    check_eq("rst_ls_done", {31'd0, mc.ls_done}, 32'd0);
    check_eq("rst_if_data", mc.if_data, 32'd0);
    check_eq("rst_ls_rdata", mc.ls_rdata, 32'd0);

    // Word fetch at 0x1000.
    new_cycle();
    mc.if_req = 1'b1; mc.if_addr = 32'h1000;
    run(8, -1, -1, -1, -1, -1, -1);
    for (int k = 0; k < 4; k++) check_eq("fetch_addr", a_log[k + 1], 32'h1000 + k);
    check_eq("fetch_idle_c5", a_log[5], 32'd0);
    check_eq("fetch_done_mask", ifd_log, 32'h40);
    check_eq("fetch_wr_mask", wr_log, 32'd0);
    check_eq("fetch_data", ifdata_log[6], 32'h00000513);

    // LS byte load and IF fetch requested together.
    new_cycle();
    mc.if_req = 1'b1; mc.if_addr = 32'h1004;
    mc.ls_req = 1'b1; mc.ls_wr = 1'b0; mc.ls_size = 2'd0; mc.ls_addr = 32'h2000;
    run(12, -1, -1, -1, -1, -1, -1);
    check_eq("arb_ls_addr", a_log[1], 32'h2000);
    check_eq("arb_ls_done_mask", lsd_log, 32'h8);
    check_eq("arb_ls_rdata", lsrd_log[3], 32'h0000007F);
    check_eq("arb_idle_c4", a_log[4], 32'd0);
    check_eq("arb_if_addr_c5", a_log[5], 32'h1004);
    check_eq("arb_if_done_mask", ifd_log, 32'h400);
    check_eq("arb_if_data", ifdata_log[10], 32'h44332211);

    // Half store 0xBEEF at 0x2002.
    new_cycle();
    mc.ls_req = 1'b1; mc.ls_wr = 1'b1; mc.ls_size = 2'd1;
    mc.ls_addr = 32'h2002; mc.ls_wdata = 32'h1234BEEF;
    run(5, -1, -1, -1, -1, -1, -1);
    check_eq("half_wr_mask", wr_log, 32'h6);
    check_eq("half_a1", a_log[1], 32'h2002);
    check_eq("half_d1", {24'd0, dout_log[1]}, 32'hEF);
    check_eq("half_a2", a_log[2], 32'h2003);
    check_eq("half_d2", {24'd0, dout_log[2]}, 32'hBE);
    check_eq("half_done_mask", lsd_log, 32'h8);

    // I/O byte store stalled by a full HCI buffer for C0..C9, fetch queued behind it.
    new_cycle();
    mc.ls_req = 1'b1; mc.ls_wr = 1'b1; mc.ls_size = 2'd0;
    mc.ls_addr = 32'h00030000; mc.ls_wdata = 32'h00000041;
    mc.if_req = 1'b1; mc.if_addr = 32'h1000;
    run(20, 0, 9, -1, -1, -1, -1);
    check_eq("io_wr_mask", wr_log, 32'h800);
    check_eq("io_addr", a_log[11], 32'h00030000);
    check_eq("io_dout", {24'd0, dout_log[11]}, 32'h41);
    check_eq("io_done_mask", lsd_log, 32'h1000);
    check_eq("io_idle_c13", a_log[13], 32'd0);
    check_eq("io_next_addr", a_log[14], 32'h1000);
    check_eq("io_next_done_mask", ifd_log, 32'h80000);

    // Word load with rdy_in low in C3..C5.
    new_cycle();
    mc.ls_req = 1'b1; mc.ls_wr = 1'b0; mc.ls_size = 2'd2; mc.ls_addr = 32'h3000;
    run(12, -1, -1, 3, 5, -1, -1);
    check_eq("pause_wr_mask", wr_log, 32'd0);
    check_eq("pause_reissue_c6", a_log[6], 32'h3002);
    check_eq("pause_done_mask", lsd_log, 32'h200);
    check_eq("pause_rdata", lsrd_log[9], 32'hEFBEADDE);

    // Fetch aborted in C2.
    new_cycle();
    mc.if_req = 1'b1; mc.if_addr = 32'h1000;
    run(6, -1, -1, -1, -1, 2, -1);
    check_eq("abort_addr_c2", a_log[2], 32'h1001);
    check_eq("abort_idle_c3", a_log[3], 32'd0);
    check_eq("abort_done_mask", ifd_log, 32'd0);
    check_eq("abort_if_data", ifdata_log[6], 32'h00000513);

    // Reset asserted in C2 of a word store.
    new_cycle();
    mc.ls_req = 1'b1; mc.ls_wr = 1'b1; mc.ls_size = 2'd2;
    mc.ls_addr = 32'h2100; mc.ls_wdata = 32'hCAFEF00D;
    run(4, -1, -1, -1, -1, -1, 2);
    check_eq("rstw_a1", a_log[1], 32'h2100);
    check_eq("rstw_d1", {24'd0, dout_log[1]}, 32'h0D);
    check_eq("rstw_wr_mask", wr_log, 32'h6);
    check_eq("rstw_a3", a_log[3], 32'd0);
    check_eq("rstw_d3", {24'd0, dout_log[3]}, 32'd0);
    check_eq("rstw_ls_rdata", lsrd_log[3], 32'd0);
    check_eq("rstw_if_data", ifdata_log[3], 32'd0);
    check_eq("rstw_done_mask", lsd_log | ifd_log, 32'd0);

    // Controller is back in IDLE and serves a fresh load.
    new_cycle();
    mc.ls_req = 1'b1; mc.ls_wr = 1'b0; mc.ls_size = 2'd0; mc.ls_addr = 32'h2000;
    run(5, -1, -1, -1, -1, -1, -1);
    check_eq("post_rst_done_mask", lsd_log, 32'h8);
    check_eq("post_rst_rdata", lsrd_log[3], 32'h0000007F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
